spi_xfer_scheduler: RTL
=======================

Name: spi_xfer_scheduler

Overview:
- Shares one SPI master shift engine between NUM_REQ requesters (e.g. CPU APB path, DMA, boot loader).
- Arbitrates round-robin, drives slave select with programmable setup/hold/gap timing, and launches byte transfers on the engine.
- Keeps slave select asserted across multi-byte bursts, returns received bytes, and aborts hung transfers with a watchdog.
- Sits in the APB SPI subsystem between the requester mux and the shift engine.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
CS_SETUP, 2, PCLK cycles SS_n is low before the first ENG_START
CS_HOLD, 2, PCLK cycles SS_n stays low after the last ENG_DONE
IDLE_GAP, 1, PCLK cycles SS_n is high before the next arbitration (min 1)
TIMEOUT, 1024, max PCLK cycles in BUSY before abort (counter width clog2(TIMEOUT+1))

Ports:
PCLK  in  1  system clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
SPI_EN  in  1  block enable (CONFIG_REG[10])
REQ  in  NUM_REQ  per-requester transfer request, held until ACK
REQ_DATA  in  8*NUM_REQ  TX byte; requester i at [8i+7:8i]
REQ_LAST  in  NUM_REQ  byte is last of burst
GNT  out  NUM_REQ  one-hot current owner
ACK  out  NUM_REQ  one-cycle pulse: byte done, RDATA valid
RDATA  out  8  received byte
ERR  out  1  one-cycle pulse on watchdog abort
BUSY  out  1  high whenever state != IDLE
SS_n  out  1  slave select to pad, active low
ENG_START  out  1  one-cycle pulse, engine loads ENG_TXDATA
ENG_TXDATA  out  8  byte to shift
ENG_BUSY  in  1  engine shifting
ENG_DONE  in  1  one-cycle pulse, byte complete
ENG_RXDATA  in  8  byte shifted in, valid with ENG_DONE

Behaviour:
- All outputs registered. Reset values: GNT=0, ACK=0, RDATA=0, ERR=0, BUSY=0, SS_n=1, ENG_START=0, ENG_TXDATA=0. Priority pointer = 0. State = IDLE.
- States: IDLE, SETUP, START, XFER, NEXT, HOLD, GAP.
- IDLE:
  - If SPI_EN and |REQ, grant the first requesting index at or after the pointer, wrapping modulo NUM_REQ.
  - Set GNT, latch the byte into ENG_TXDATA and latch REQ_LAST.
  - SS_n<=0, pointer<=grant+1 (wraps), counter<=CS_SETUP, go to SETUP.
- SETUP: decrement the counter each cycle. At 0, go to START. SS_n is low for exactly CS_SETUP cycles before ENG_START.
- START:
  - If ENG_BUSY=0, pulse ENG_START, clear the watchdog, go to XFER.
  - Otherwise wait in START. The watchdog also runs here.
- XFER:
  - On ENG_DONE: RDATA<=ENG_RXDATA, pulse ACK[g] in the next cycle, go to NEXT.
  - The watchdog increments each cycle. At TIMEOUT: pulse ERR, no ACK, go to HOLD.
- NEXT:
  - If latched last=0, REQ[g]=1 and SPI_EN=1: latch the new byte and last, pulse ENG_START, go to XFER. SS_n stays low and there is no re-arbitration.
  - Otherwise, counter<=CS_HOLD, go to HOLD.
- HOLD: SS_n low for CS_HOLD cycles, then SS_n<=1, GNT<=0, go to GAP.
- GAP: IDLE_GAP cycles with SS_n=1, then IDLE. Minimum SS_n high time is IDLE_GAP+1 cycles.
- Back-to-back throughput: one byte per (engine time + 2) PCLK in a burst.
- SPI_EN deasserted:
  - In SETUP or START: go to HOLD with no ENG_START and no ACK.
  - In XFER: complete normally (ACK issued), then NEXT falls to HOLD.
- Boundary cases:
  - ENG_DONE outside XFER is ignored.
  - Requester dropping REQ before ACK is a protocol violation. The latched byte is still sent and ACK still pulses.
  - A single requester re-requesting is granted again after GAP.
  - REQ changes on non-granted indices have no effect until IDLE.
- Asynchronous reset mid-transfer: immediate return to IDLE and SS_n=1. No ACK is issued. The engine is reset by the same PRESETn.

Test Plan:
- Single byte, req0 with 0xA5, last=1, engine returns 0x3C after 16 cycles: SS_n low 2 cycles before ENG_START, ACK[0] with RDATA=0x3C, SS_n high 2 cycles after ENG_DONE, BUSY=0 after GAP.
- Round-robin, REQ=2'b11 continuously with last=1: GNT sequence 01,10,01,10; each SS_n high gap ≥2 cycles.
- Burst, req1 sends 0x11,0x22,0x33 with last on 0x33: SS_n stays low across all three, 3 ACK[1] pulses, ENG_START 1 cycle after each ACK, no GNT change while req0 waits.
- Watchdog with TIMEOUT=8 and the engine never asserting DONE: ERR pulses at cycle 8 of XFER, no ACK, SS_n high after CS_HOLD, next request served normally.
- SPI_EN dropped during SETUP: no ENG_START, SS_n returns high, GNT clears. SPI_EN dropped during XFER: ACK still issued, then HOLD.
- PRESETn asserted mid-XFER: all outputs at reset values immediately. After release, REQ[1] alone is granted first.

Source files
------------

// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler sharing one SPI shift engine between NUM_REQ requesters,
// with slave-select setup/hold/gap timing, multi-byte bursts and a transfer watchdog.
module spi_xfer_scheduler #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned IDLE_GAP = 1,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 SPI_EN,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   GNT,
  output logic [NUM_REQ-1:0]   ACK,
  output logic [7:0]           RDATA,
  output logic                 ERR,
  output logic                 BUSY,
  output logic                 SS_n,
  output logic                 ENG_START,
  output logic [7:0]           ENG_TXDATA,
  input  logic                 ENG_BUSY,
  input  logic                 ENG_DONE,
  input  logic [7:0]           ENG_RXDATA
);

  localparam int unsigned PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CMAX = (CS_SETUP > CS_HOLD) ?
                                 ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP) :
                                 ((CS_HOLD  > IDLE_GAP) ? CS_HOLD  : IDLE_GAP);
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned WW   = $clog2(TIMEOUT + 1);

  // Counters exit on the cycle they read 1 (or 0). START adds one cycle after
  // SETUP, and NEXT already counts as the first hold cycle after ENG_DONE.
  localparam logic [CW-1:0] C_SETUP    = CW'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [CW-1:0] C_HOLD     = CW'(CS_HOLD);
  localparam logic [CW-1:0] C_HOLD_NXT = CW'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
  localparam logic [CW-1:0] C_GAP      = CW'(IDLE_GAP);
  localparam logic [WW-1:0] W_TO       = WW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_XFER, S_NEXT, S_HOLD, S_GAP
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_gidx;
  logic [CW-1:0]        r_cnt;
  logic [WW-1:0]        r_wd;
  logic                 r_last;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic [7:0]           r_rdata;
  logic                 r_err;
  logic                 r_busy;
  logic                 r_ss_n;
  logic                 r_eng_start;
  logic [7:0]           r_txdata;

  logic [PW-1:0]        w_pick;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [PW-1:0]        w_ptr_nxt;
  logic                 w_any;
  logic                 w_cnt_last;
  logic [WW-1:0]        w_wd_inc;
  logic                 w_wd_to;

  // Scan offsets from farthest to nearest so the nearest requester at or after
  // the pointer is the final assignment.
  always_comb begin
    int unsigned v_idx;
    v_idx  = 0;
    w_pick = r_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_idx = int'(r_ptr) + (NUM_REQ - 1 - k);
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (REQ[PW'(v_idx)]) w_pick = PW'(v_idx);
    end
  end

  always_comb begin
    w_pick_oh         = '0;
    w_pick_oh[w_pick] = 1'b1;
  end

  assign w_ptr_nxt  = (w_pick == PW'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
  assign w_any      = |REQ;
  assign w_cnt_last = (r_cnt == '0) || (r_cnt == CW'(1));
  assign w_wd_inc   = r_wd + 1'b1;
  assign w_wd_to    = (w_wd_inc == W_TO);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_cnt       <= '0;
      r_wd        <= '0;
      r_last      <= 1'b0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_ss_n      <= 1'b1;
      r_eng_start <= 1'b0;
      r_txdata    <= '0;
    end else begin
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_eng_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (SPI_EN && w_any) begin
            r_gnt    <= w_pick_oh;
            r_gidx   <= w_pick;
            r_txdata <= REQ_DATA[{w_pick, 3'b000} +: 8];
            r_last   <= REQ_LAST[w_pick];
            r_ss_n   <= 1'b0;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= C_SETUP;
            r_wd     <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!SPI_EN) begin
            r_cnt   <= C_HOLD;
            r_state <= S_HOLD;
          end else if (w_cnt_last) begin
            r_state <= S_START;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_START: begin
          if (!SPI_EN) begin
            r_cnt   <= C_HOLD;
            r_state <= S_HOLD;
          end else if (!ENG_BUSY) begin
            r_eng_start <= 1'b1;
            r_wd        <= '0;
            r_state     <= S_XFER;
          end else if (w_wd_to) begin
            r_err   <= 1'b1;
            r_cnt   <= C_HOLD;
            r_state <= S_HOLD;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_XFER: begin
          if (ENG_DONE) begin
            r_rdata <= ENG_RXDATA;
            r_ack   <= r_gnt;
            r_state <= S_NEXT;
          end else if (w_wd_to) begin
            r_err   <= 1'b1;
            r_cnt   <= C_HOLD;
            r_state <= S_HOLD;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_NEXT: begin
          if (!r_last && REQ[r_gidx] && SPI_EN) begin
            r_txdata    <= REQ_DATA[{r_gidx, 3'b000} +: 8];
            r_last      <= REQ_LAST[r_gidx];
            r_eng_start <= 1'b1;
            r_wd        <= '0;
            r_state     <= S_XFER;
          end else begin
            r_cnt   <= C_HOLD_NXT;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_cnt_last) begin
            r_ss_n  <= 1'b1;
            r_gnt   <= '0;
            r_cnt   <= C_GAP;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (w_cnt_last) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign GNT        = r_gnt;
  assign ACK        = r_ack;
  assign RDATA      = r_rdata;
  assign ERR        = r_err;
  assign BUSY       = r_busy;
  assign SS_n       = r_ss_n;
  assign ENG_START  = r_eng_start;
  assign ENG_TXDATA = r_txdata;

endmodule
